// File: rtl/decode_serial_ctrl_pkg.sv
// Shared core definitions for the decode serialization controller.
package decode_serial_ctrl_pkg;

   localparam int unsigned CNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      WAIT_COMMIT
   } serialState_t;

endpackage

// File: rtl/decode_serial_ctrl_if.sv
// Decode-to-IB handshake bundle for the serialization controller.
interface decode_serial_ctrl_if
   import decode_serial_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);
   logic                 decValid_i;
   logic                 decSerial_i;
   logic                 ibReady_i;
   logic                 robEmpty_i;
   logic                 serialCommit_i;
   logic                 flush_i;
   logic                 ibValid_o;
   logic                 decStall_o;
   logic                 serialBusy_o;
   logic [CNT_WIDTH-1:0] stallCycles_o;
   logic [CNT_WIDTH-1:0] serialIssued_o;

   modport master (
      output decValid_i, decSerial_i, ibReady_i, robEmpty_i, serialCommit_i, flush_i,
      input  ibValid_o, decStall_o, serialBusy_o, stallCycles_o, serialIssued_o
   );

   modport slave (
      input  decValid_i, decSerial_i, ibReady_i, robEmpty_i, serialCommit_i, flush_i,
      output ibValid_o, decStall_o, serialBusy_o, stallCycles_o, serialIssued_o
   );
endinterface

// File: rtl/decode_serial_ctrl_sat.sv
// Saturating up-counter with synchronous active-high clear.
module SatCounter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/decode_serial_ctrl.sv
// Serializes CSR/FENCE/SRET/SCALL-class instructions between decode and the IB:
// drain the ROB, issue alone, then block the IB until the instruction commits.
module decode_serial_ctrl
   import decode_serial_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input logic              clk,
   input logic              reset,
   decode_serial_ctrl_if.slave bus
);
   serialState_t         state_q, state_d;
   logic [CNT_WIDTH-1:0] issued_q, issued_d;
   logic                 issue;
   logic                 ibValid;
   logic                 decStall;

   always_comb begin
      state_d  = state_q;
      ibValid  = 1'b0;
      decStall = 1'b0;
      issue    = 1'b0;
      // Reset silences outputs; flush overrides both commit and the drain issue.
      if (!reset && bus.flush_i) begin
         state_d = IDLE;
      end else if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (bus.decValid_i && bus.decSerial_i) begin
                  decStall = 1'b1;
                  state_d  = DRAIN;
               end else begin
                  ibValid  = bus.decValid_i & bus.ibReady_i;
                  decStall = bus.decValid_i & ~bus.ibReady_i;
               end
            end
            DRAIN: begin
               if (!bus.decValid_i) begin
                  decStall = 1'b1;
                  state_d  = IDLE;
               end else if (bus.robEmpty_i && bus.ibReady_i) begin
                  ibValid = 1'b1;
                  issue   = 1'b1;
                  state_d = WAIT_COMMIT;
               end else begin
                  decStall = 1'b1;
               end
            end
            WAIT_COMMIT: begin
               decStall = bus.decValid_i;
               if (bus.serialCommit_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      issued_d = issued_q;
      if (issue) begin
         issued_d = issued_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
      end
   end

   SatCounter #(
      .WIDTH (CNT_WIDTH)
   ) u_stallCnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   ((state_q == DRAIN) || (state_q == WAIT_COMMIT)),
      .count_o (bus.stallCycles_o)
   );

   assign bus.ibValid_o      = ibValid;
   assign bus.decStall_o     = decStall;
   assign bus.serialBusy_o   = (state_q != IDLE) && !reset;
   assign bus.serialIssued_o = issued_q;
endmodule

// File: tb/tb_decode_serial_ctrl.sv
// Randomized bench for decode_serial_ctrl against an abstract serialization model.
module tb_decode_serial_ctrl;
   localparam int unsigned W   = 4;
   localparam int unsigned MAX = (1 << W) - 1;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   decode_serial_ctrl_if #(.CNT_WIDTH(W)) bus ();

   decode_serial_ctrl #(.CNT_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: a serializing instruction is either waiting for the ROB to empty
   // (pending) or issued and awaiting retirement (inflight).
   bit          model_ok = 1'b0;
   bit          pending  = 1'b0;
   bit          inflight = 1'b0;
   int unsigned m_stall  = 0;
   int unsigned m_issued = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         pending  = 1'b0;
         inflight = 1'b0;
         m_stall  = 0;
         m_issued = 0;
         model_ok = 1'b1;
      end else begin
         if ((pending || inflight) && m_stall < MAX) m_stall = m_stall + 1;
         if (bus.flush_i) begin
            pending  = 1'b0;
            inflight = 1'b0;
         end else if (inflight) begin
            if (bus.serialCommit_i) inflight = 1'b0;
         end else if (pending) begin
            if (!bus.decValid_i) begin
               pending = 1'b0;
            end else if (bus.robEmpty_i && bus.ibReady_i) begin
               pending  = 1'b0;
               inflight = 1'b1;
               m_issued = (m_issued + 1) % (MAX + 1);
            end
         end else if (bus.decValid_i && bus.decSerial_i) begin
            pending = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      bit e_ib, e_st, e_busy;
      if (model_ok) begin
         e_busy = !reset && (pending || inflight);
         e_ib   = 1'b0;
         e_st   = 1'b0;
         if (reset || bus.flush_i) begin
            e_ib = 1'b0;
            e_st = 1'b0;
         end else if (inflight) begin
            e_st = bus.decValid_i;
         end else if (pending) begin
            e_ib = bus.decValid_i && bus.robEmpty_i && bus.ibReady_i;
            e_st = !e_ib;
         end else if (bus.decValid_i && bus.decSerial_i) begin
            e_st = 1'b1;
         end else begin
            e_ib = bus.decValid_i && bus.ibReady_i;
            e_st = bus.decValid_i && !bus.ibReady_i;
         end
         check("ibValid",      int'(bus.ibValid_o),      int'(e_ib));
         check("decStall",     int'(bus.decStall_o),     int'(e_st));
         check("serialBusy",   int'(bus.serialBusy_o),   int'(e_busy));
         check("stallCycles",  int'(bus.stallCycles_o),  m_stall);
         check("serialIssued", int'(bus.serialIssued_o), m_issued);
      end
   end

   task automatic cyc(input bit dv, input bit ds, input bit rdy, input bit rob,
                      input bit com, input bit fl, input bit rst);
      @(posedge clk);
      #1;
      bus.decValid_i     = dv;
      bus.decSerial_i    = ds;
      bus.ibReady_i      = rdy;
      bus.robEmpty_i     = rob;
      bus.serialCommit_i = com;
      bus.flush_i        = fl;
      reset              = rst;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      bus.decValid_i = 1'b0; bus.decSerial_i = 1'b0; bus.ibReady_i = 1'b0;
      bus.robEmpty_i = 1'b0; bus.serialCommit_i = 1'b0; bus.flush_i = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("rst_ibValid", int'(bus.ibValid_o), 0);
      check("rst_busy",    int'(bus.serialBusy_o), 0);

      // Non-serial stream, IB always ready.
      for (int i = 0; i < 8; i++) begin
         bit dv = 1'($urandom_range(0, 1));
         cyc(dv, 0, 1, 0, 0, 0, 0);
         check("ns_follow", int'(bus.ibValid_o), int'(dv));
      end
      check("ns_stall0", int'(bus.stallCycles_o), 0);

      // Serial entry, ROB busy for 5 DRAIN cycles, issue on the 6th.
      cyc(1, 1, 1, 0, 0, 0, 0);
      check("ser_entry_stall", int'(bus.decStall_o), 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 1, 0, 0, 0, 0);
         check("drain_hold", int'(bus.ibValid_o), 0);
      end
      cyc(1, 1, 1, 1, 0, 0, 0);
      check("drain_issue", int'(bus.ibValid_o), 1);
      // Non-serial held during WAIT_COMMIT, commit on the 5th cycle.
      cyc(1, 0, 1, 1, 0, 0, 0);
      check("issue_stallcnt", int'(bus.stallCycles_o), 6);
      check("issue_count",    int'(bus.serialIssued_o), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 1, 0, 0, 0);
         check("wait_stall", int'(bus.decStall_o), 1);
      end
      cyc(1, 0, 1, 1, 1, 0, 0);
      check("wait_commit_ib", int'(bus.ibValid_o), 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      check("post_commit_ib", int'(bus.ibValid_o), 1);

      // Flush and commit together in WAIT_COMMIT.
      cyc(1, 1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 0, 0, 0);
      check("issue2", int'(bus.serialIssued_o), 1);
      cyc(1, 0, 1, 1, 1, 1, 0);
      check("flush_ib",  int'(bus.ibValid_o), 0);
      check("flush_st",  int'(bus.decStall_o), 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      check("flush_idle", int'(bus.serialBusy_o), 0);
      check("flush_ib2",  int'(bus.ibValid_o), 1);

      // Reset during WAIT_COMMIT.
      cyc(1, 1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 1);
      check("rstw_st", int'(bus.decStall_o), 0);
      cyc(0, 0, 1, 1, 0, 0, 0);
      check("rstw_busy",   int'(bus.serialBusy_o), 0);
      check("rstw_stall",  int'(bus.stallCycles_o), 0);
      check("rstw_issued", int'(bus.serialIssued_o), 0);

      // Long DRAIN saturates the stall counter.
      cyc(1, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) cyc(1, 1, 1, 0, 0, 0, 0);
      check("sat_stall", int'(bus.stallCycles_o), 15);
      cyc(1, 1, 1, 0, 0, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 63) == 0));
      end

      cyc(0, 0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
